// File: rtl/dcache_responder_if.sv
// Request/response bundle between the initiator (ufp side), the cache, and
// the memory/arbiter (dfp side). The cache takes the slave view; the
// environment that drives requests and serves lines takes the master view.
interface dcache_responder_if;
  logic [31:0]  ufp_addr;
  logic [3:0]   ufp_rmask;
  logic [3:0]   ufp_wmask;
  logic [31:0]  ufp_wdata;
  logic [31:0]  ufp_rdata;
  logic         ufp_resp;

  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;

  modport slave (
    input  ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata, dfp_rdata, dfp_resp,
    output ufp_rdata, ufp_resp, dfp_addr, dfp_read, dfp_write, dfp_wdata
  );

  modport master (
    output ufp_addr, ufp_rmask, ufp_wmask, ufp_wdata, dfp_rdata, dfp_resp,
    input  ufp_rdata, ufp_resp, dfp_addr, dfp_read, dfp_write, dfp_wdata
  );
endinterface

// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache with flop storage.
// One word request in flight; misses fill (and evict dirty victims) as whole
// 256-bit lines over dfp. Every accepted request runs to completion so the
// initiator always sees exactly one ufp_resp per request.
module dcache_responder #(
  parameter int SETS      = 16,
  parameter int LINE_BITS = 256
) (
  input  logic              clk,
  input  logic              rst,
  dcache_responder_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - 5 - IDX_W;
  localparam int WORDS = LINE_BITS / 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_e;

  // Latched request; byte-offset bits are never needed so only the word
  // address is kept.
  typedef struct packed {
    logic [31:2] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } req_t;

  state_e                           state_q, state_d;
  req_t                             req_q, req_d;
  logic [SETS-1:0]                  valid_q, valid_d;
  logic [SETS-1:0]                  dirty_q, dirty_d;
  logic [SETS-1:0][TAG_W-1:0]       tag_q, tag_d;
  logic [SETS-1:0][WORDS-1:0][31:0] data_q, data_d;

  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        req_tag;
  logic [2:0]              off;
  logic                    hit;
  logic                    is_store;
  logic [WORDS-1:0][31:0]  cur_line;
  logic                    unused_addr_lsb;

  assign idx      = req_q.addr[4+IDX_W:5];
  assign req_tag  = req_q.addr[31:5+IDX_W];
  assign off      = req_q.addr[4:2];
  assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);
  assign is_store = |req_q.wmask;
  assign cur_line = data_q[idx];

  // Byte lanes within the word are selected by the masks, not the address.
  assign unused_addr_lsb = ^bus.ufp_addr[1:0];

  // Outputs decode the registered state so dfp strobes stay stable until
  // dfp_resp; the hit response is produced in the COMPARE cycle itself.
  always_comb begin
    bus.ufp_resp  = (state_q == S_COMPARE) && hit;
    bus.ufp_rdata = '0;
    if ((state_q == S_COMPARE) && hit && (req_q.rmask != 4'h0))
      bus.ufp_rdata = cur_line[off];
    bus.dfp_write = (state_q == S_WRITEBACK);
    bus.dfp_read  = (state_q == S_ALLOCATE);
    bus.dfp_addr  = '0;
    bus.dfp_wdata = '0;
    if (state_q == S_WRITEBACK) begin
      bus.dfp_addr  = {tag_q[idx], idx, 5'b0};
      bus.dfp_wdata = cur_line;
    end else if (state_q == S_ALLOCATE) begin
      bus.dfp_addr  = {req_q.addr[31:5], 5'b0};
    end
  end

  // Next-state, request capture and array updates.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    unique case (state_q)
      S_IDLE: begin
        if ((bus.ufp_rmask | bus.ufp_wmask) != 4'h0) begin
          req_d.addr  = bus.ufp_addr[31:2];
          // A request with both masks set is a store; drop the read mask so
          // the response carries no read data.
          req_d.rmask = (bus.ufp_wmask != 4'h0) ? 4'h0 : bus.ufp_rmask;
          req_d.wmask = bus.ufp_wmask;
          req_d.wdata = bus.ufp_wdata;
          state_d     = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (hit) begin
          if (is_store) begin
            for (int b = 0; b < 4; b++)
              if (req_q.wmask[b])
                data_d[idx][off][b*8 +: 8] = req_q.wdata[b*8 +: 8];
            dirty_d[idx] = 1'b1;
          end
          state_d = S_IDLE;
        end else if (valid_q[idx] && dirty_q[idx]) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        if (bus.dfp_resp) begin
          dirty_d[idx] = 1'b0;
          state_d      = S_ALLOCATE;
        end
      end
      S_ALLOCATE: begin
        if (bus.dfp_resp) begin
          data_d[idx]  = bus.dfp_rdata;
          tag_d[idx]   = req_tag;
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: reset aborts any request and invalidates every line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag/data storage is not cleared; valid bits gate its use. Updates are
  // suppressed under reset so an aborted fill leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: stimulus pushes expected ufp responses
// and dfp requests into queues; a ufp monitor and the memory model pop and
// compare them when the DUT presents a response or starts a line transfer.
module tb_dcache_responder;
  localparam int LAT = 3;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;
  int   dfp_resp_cyc;
  int   conflicts;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] w1;
  } dfp_exp_t;

  logic [31:0]  ufp_exp[$];
  dfp_exp_t     dfp_exp[$];
  logic [255:0] mem [bit [26:0]];

  dcache_responder_if bus();

  dcache_responder #(.SETS(16), .LINE_BITS(256)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic logic [255:0] get_line(input logic [31:0] a);
    logic [255:0] l;
    bit [26:0]    k;
    k = a[31:5];
    if (mem.exists(k)) return mem[k];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = {a[15:0], 16'(i)};
    return l;
  endfunction

  // Memory model: serves one dfp strobe at a time after LAT cycles and
  // checks each new strobe against the expected dfp queue.
  initial begin
    int          cnt;
    dfp_exp_t    e;
    bit [26:0]   k;
    cnt = 0;
    conflicts = 0;
    dfp_resp_cyc = 0;
    bus.dfp_resp  = 1'b0;
    bus.dfp_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.dfp_read && bus.dfp_write) conflicts++;
      if (bus.dfp_resp) begin
        bus.dfp_resp = 1'b0;
        cnt = 0;
      end else if (bus.dfp_read || bus.dfp_write) begin
        if (cnt == 0) begin
          if (dfp_exp.size() == 0) begin
            chk(1'b0, "dfp_unexpected_req", bus.dfp_addr, 0);
          end else begin
            e = dfp_exp.pop_front();
            chk(bus.dfp_write == e.wr, "dfp_kind_is_write", bus.dfp_write, e.wr);
            chk(bus.dfp_addr == e.addr, "dfp_addr", bus.dfp_addr, e.addr);
            if (e.wr) chk(bus.dfp_wdata[63:32] == e.w1, "dfp_wdata_word1", bus.dfp_wdata[63:32], e.w1);
          end
        end
        cnt++;
        if (cnt >= LAT) begin
          k = bus.dfp_addr[31:5];
          if (bus.dfp_write) mem[k] = bus.dfp_wdata;
          else bus.dfp_rdata = get_line(bus.dfp_addr);
          bus.dfp_resp = 1'b1;
          dfp_resp_cyc = cyc;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ufp monitor: every response must match the next expected word.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (bus.ufp_resp) begin
        if (ufp_exp.size() == 0) begin
          chk(1'b0, "ufp_resp_unexpected", bus.ufp_rdata, 0);
        end else begin
          e = ufp_exp.pop_front();
          chk(bus.ufp_rdata == e, "ufp_rdata", bus.ufp_rdata, e);
        end
      end
    end
  end

  // Issue one request, hold it until ufp_resp, drop it in the response
  // cycle and leave one idle cycle. exp_lat = 0 skips the latency check.
  task automatic do_req(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, input logic [31:0] exp, input int exp_lat,
                        input string nm, output int resp_cyc);
    int n;
    bit got;
    ufp_exp.push_back(exp);
    bus.ufp_addr  = a;
    bus.ufp_rmask = rm;
    bus.ufp_wmask = wm;
    bus.ufp_wdata = wd;
    n = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.ufp_resp) got = 1'b1;
    end
    resp_cyc = cyc;
    bus.ufp_rmask = 4'h0;
    bus.ufp_wmask = 4'h0;
    bus.ufp_addr  = '0;
    bus.ufp_wdata = '0;
    if (!got) chk(1'b0, {nm, "_timeout"}, n, 200);
    else if (exp_lat != 0) chk(n == exp_lat, {nm, "_latency"}, n, exp_lat);
    @(posedge clk);
    #1;
  endtask

  function automatic dfp_exp_t mk(input bit wr, input logic [31:0] a, input logic [31:0] w1);
    dfp_exp_t e;
    e.wr = wr;
    e.addr = a;
    e.w1 = w1;
    return e;
  endfunction

  initial begin
    logic [255:0] l;
    int rc;
    int n;
    checks = 0;
    failures = 0;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'h1000_0000 + i;
    l[63:32] = 32'hDEAD_BEEF;
    mem[27'h80] = l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'h1200_0000 + i;
    l[63:32] = 32'h1234_5678;
    mem[27'h90] = l;

    bus.ufp_addr = '0; bus.ufp_rmask = '0; bus.ufp_wmask = '0; bus.ufp_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk(bus.ufp_resp == 1'b0, "rst_ufp_resp", bus.ufp_resp, 0);
    chk(bus.ufp_rdata == 32'h0, "rst_ufp_rdata", bus.ufp_rdata, 0);
    chk(bus.dfp_read == 1'b0, "rst_dfp_read", bus.dfp_read, 0);
    chk(bus.dfp_write == 1'b0, "rst_dfp_write", bus.dfp_write, 0);
    chk(bus.dfp_addr == 32'h0, "rst_dfp_addr", bus.dfp_addr, 0);
    chk(bus.dfp_wdata == 256'h0, "rst_dfp_wdata", bus.dfp_wdata, 0);
    rst = 1'b0;

    // 1: cold miss, response one cycle after the dfp_resp cycle
    dfp_exp.push_back(mk(1'b0, 32'h0000_1000, 32'h0));
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF, 0, "t1_cold", rc);
    chk(rc == dfp_resp_cyc + 1, "t1_resp_after_fill", rc, dfp_resp_cyc + 1);

    // 2: read hit
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, 32'hDEAD_BEEF, 1, "t2_hit", rc);

    // 3: byte store hit then reload
    do_req(32'h0000_1004, 4'h0, 4'b0100, 32'h00AB_0000, 32'h0, 1, "t3_store", rc);
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, 32'hDEAB_BEEF, 1, "t3_load", rc);
    chk(dut.dirty_q[0] == 1'b1, "t3_dirty0", dut.dirty_q[0], 1);

    // 4: dirty conflict miss -> writeback then fill
    dfp_exp.push_back(mk(1'b1, 32'h0000_1000, 32'hDEAB_BEEF));
    dfp_exp.push_back(mk(1'b0, 32'h0000_1200, 32'h0));
    do_req(32'h0000_1204, 4'hF, 4'h0, 32'h0, 32'h1234_5678, 0, "t4_conflict", rc);

    // 4b: clean conflict miss brings back the written-back line
    dfp_exp.push_back(mk(1'b0, 32'h0000_1000, 32'h0));
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, 32'hDEAB_BEEF, 0, "t4b_refill", rc);

    // 5: reset while dfp_read is high
    dfp_exp.push_back(mk(1'b0, 32'h0000_2040, 32'h0));
    bus.ufp_addr = 32'h0000_2044; bus.ufp_rmask = 4'hF;
    n = 0;
    while (!bus.dfp_read && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(bus.dfp_read == 1'b1, "t5_reached_allocate", bus.dfp_read, 1);
    bus.ufp_addr = '0; bus.ufp_rmask = 4'h0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk(bus.dfp_read == 1'b0, "t5_dfp_read", bus.dfp_read, 0);
    chk(bus.dfp_write == 1'b0, "t5_dfp_write", bus.dfp_write, 0);
    chk(bus.dfp_addr == 32'h0, "t5_dfp_addr", bus.dfp_addr, 0);
    chk(bus.ufp_resp == 1'b0, "t5_ufp_resp", bus.ufp_resp, 0);
    chk(bus.ufp_rdata == 32'h0, "t5_ufp_rdata", bus.ufp_rdata, 0);
    rst = 1'b0;
    dfp_exp.push_back(mk(1'b0, 32'h0000_2040, 32'h0));
    do_req(32'h0000_2044, 4'hF, 4'h0, 32'h0, 32'h2040_0001, 0, "t5_remiss", rc);

    // 6: back-to-back hits on line 0x1000, plus a both-masks store
    dfp_exp.push_back(mk(1'b0, 32'h0000_1000, 32'h0));
    do_req(32'h0000_1008, 4'hF, 4'h0, 32'h0, 32'h1000_0002, 0, "t6_refill", rc);
    do_req(32'h0000_1004, 4'hF, 4'h0, 32'h0, 32'hDEAB_BEEF, 1, "t6_hit_a", rc);
    do_req(32'h0000_100C, 4'h0, 4'b0011, 32'h0000_CAFE, 32'h0, 1, "t6_store", rc);
    do_req(32'h0000_100C, 4'hF, 4'h0, 32'h0, 32'h1000_CAFE, 1, "t6_hit_b", rc);
    do_req(32'h0000_1010, 4'hF, 4'b1000, 32'h5500_0000, 32'h0, 1, "t6_both_masks", rc);
    do_req(32'h0000_1010, 4'hF, 4'h0, 32'h0, 32'h5500_0004, 1, "t6_hit_c", rc);

    repeat (5) @(posedge clk);
    #1;
    chk(ufp_exp.size() == 0, "ufp_exp_drained", ufp_exp.size(), 0);
    chk(dfp_exp.size() == 0, "dfp_exp_drained", dfp_exp.size(), 0);
    chk(conflicts == 0, "dfp_read_write_overlap", conflicts, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
